// File: rtl/fpmul_scheduler_if.sv
// Handshake/bus bundle between the requesters, the shared multiplier and the fpmul_scheduler.
// Latency: none (wires only).
// Backpressure: carries req_valid/req_ready and rsp_valid/rsp_ready; the bundle adds no buffering.
// Ports: req_* (NREQ packed operand pairs, one-hot req_ready), mul_* (multiplier operands/result),
//        rsp_* (tagged product), busy and ops_done status.
interface fpmul_scheduler_if #(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_dataA;
  logic [32*NREQ-1:0]   req_dataB;
  logic [NREQ-1:0]      req_ready;
  logic [31:0]          mul_dataA;
  logic [31:0]          mul_dataB;
  logic [31:0]          mul_dataR;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [31:0]          rsp_data;
  logic                 rsp_ready;
  logic                 busy;
  logic [15:0]          ops_done;

  // Environment side: requesters, the multiplier result and the response consumer.
  modport master (
    output req_valid, req_dataA, req_dataB, mul_dataR, rsp_ready,
    input  req_ready, mul_dataA, mul_dataB, rsp_valid, rsp_id, rsp_data, busy, ops_done
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_dataA, req_dataB, mul_dataR, rsp_ready,
    output req_ready, mul_dataA, mul_dataB, rsp_valid, rsp_id, rsp_data, busy, ops_done
  );
endinterface

// File: rtl/fpmul_scheduler.sv
// Round-robin scheduler sharing one combinational FP32 multiplier among NREQ requesters.
// Latency: accept at edge T, product captured at T+LAT, response valid after T+LAT; LAT+2 cycles per op.
// Backpressure: one op in flight; req_ready stays low until the response handshakes, rsp_* hold while rsp_ready=0.
// Ports: clk, reset (async, active-high), bus (fpmul_scheduler_if.slave: req_*, mul_*, rsp_*, busy, ops_done).
module fpmul_scheduler #(
  parameter int NREQ = 4,
  parameter int LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  fpmul_scheduler_if.slave  bus
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  owner;
  logic [IDW-1:0]  winner;
  logic            found;
  logic [NREQ-1:0] grant;
  logic [31:0]     win_a, win_b;
  logic [3:0]      wait_cnt;
  logic [31:0]     mul_a, mul_b, rsp_q;
  logic            busy_q;
  logic [15:0]     ops_q;
  logic            accept;
  logic            rsp_hs;

  // Round-robin search starting at ptr; sum stays below 2*NREQ so one
  // conditional subtraction implements the modulo for any NREQ.
  always_comb begin
    logic [IDW:0] sum;
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) begin
        sum = sum - (IDW+1)'(NREQ);
      end
      if (!found && bus.req_valid[sum[IDW-1:0]]) begin
        found  = 1'b1;
        winner = sum[IDW-1:0];
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (winner == IDW'(k)) begin
        win_a = bus.req_dataA[32*k +: 32];
        win_b = bus.req_dataB[32*k +: 32];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (state == IDLE && found) begin
      grant[winner] = 1'b1;
    end
  end

  assign accept = |(grant & bus.req_valid);
  assign rsp_hs = (state == RESP) && bus.rsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)          state_nxt = EXEC;
      EXEC:    if (wait_cnt == '0)  state_nxt = RESP;
      RESP:    if (rsp_hs)          state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= '0;
      owner    <= '0;
      wait_cnt <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      rsp_q    <= '0;
      busy_q   <= 1'b0;
      ops_q    <= '0;
    end else begin
      // busy tracks the next state so it always equals (state != IDLE).
      busy_q <= (state_nxt != IDLE);
      if (accept) begin
        mul_a    <= win_a;
        mul_b    <= win_b;
        owner    <= winner;
        wait_cnt <= 4'(LAT - 1);
      end
      if (state == EXEC) begin
        if (wait_cnt == '0) begin
          rsp_q <= bus.mul_dataR;
        end else begin
          wait_cnt <= wait_cnt - 4'd1;
        end
      end
      if (rsp_hs) begin
        ptr <= (owner == IDW'(NREQ - 1)) ? '0 : owner + 1'b1;
        if (ops_q != 16'hFFFF) begin
          ops_q <= ops_q + 16'd1;
        end
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.mul_dataA = mul_a;
  assign bus.mul_dataB = mul_b;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = owner;
  assign bus.rsp_data  = rsp_q;
  assign bus.busy      = busy_q;
  assign bus.ops_done  = ops_q;

endmodule

// File: tb/tb_fpmul_scheduler.sv
// Directed bench for fpmul_scheduler: one LAT=1 instance and one LAT=4 instance, NREQ=4 each.
// The shared multiplier is stood in for by a lookup of hand-computed FP32 products.
module tb_fpmul_scheduler;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   n_chk;
  int   n_fail;

  fpmul_scheduler_if #(.NREQ(4)) bus_a ();
  fpmul_scheduler_if #(.NREQ(4)) bus_b ();

  fpmul_scheduler #(.NREQ(4), .LAT(1)) dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
  fpmul_scheduler #(.NREQ(4), .LAT(4)) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

  // 2.0*3.0 = 6.0 and 1.5*1.5 = 2.25; anything else gets a distinct filler.
  function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (a == 32'h3FC00000 && b == 32'h3FC00000) return 32'h40100000;
    return a ^ b ^ 32'h5A5A5A5A;
  endfunction

  assign bus_a.mul_dataR = fmul_ref(bus_a.mul_dataA, bus_a.mul_dataB);
  assign bus_b.mul_dataR = fmul_ref(bus_b.mul_dataA, bus_b.mul_dataB);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int oh2idx(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Wait (bounded) for dut_a to return to IDLE, checking any product it hands over.
  task automatic drain_a(input logic [31:0] exp_r);
    int n;
    n = 0;
    while (bus_a.busy && n < 20) begin
      if (bus_a.rsp_valid && bus_a.rsp_ready) chk("drain rsp_data", bus_a.rsp_data, exp_r);
      @(negedge clk);
      n++;
    end
    chk("drain idle busy", {31'b0, bus_a.busy}, 32'd0);
  endtask

  // One op on dut_a from requester id with rsp_ready high.
  task automatic op_a(input int id, input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
    bus_a.req_dataA[32*id +: 32] = a;
    bus_a.req_dataB[32*id +: 32] = b;
    bus_a.req_valid = 4'b0001 << id;
    #1;
    chk("op req_ready", {28'b0, bus_a.req_ready}, 32'(4'b0001 << id));
    @(negedge clk);
    bus_a.req_valid = '0;
    drain_a(r);
  endtask

  initial begin
    int g_id[5];
    int g_cyc[5];
    int ng;
    int cyc;
    int n;
    int seen;
    logic [31:0] a_hold;
    logic [31:0] b_hold;

    n_chk  = 0;
    n_fail = 0;
    rst_a  = 1'b1;
    rst_b  = 1'b1;
    bus_a.req_valid = '0; bus_a.req_dataA = '0; bus_a.req_dataB = '0; bus_a.rsp_ready = 1'b1;
    bus_b.req_valid = '0; bus_b.req_dataA = '0; bus_b.req_dataB = '0; bus_b.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);

    // ---- reset values
    chk("rst req_ready", {28'b0, bus_a.req_ready}, 32'd0);
    chk("rst mul_dataA", bus_a.mul_dataA, 32'd0);
    chk("rst mul_dataB", bus_a.mul_dataB, 32'd0);
    chk("rst rsp_valid", {31'b0, bus_a.rsp_valid}, 32'd0);
    chk("rst rsp_id", {30'b0, bus_a.rsp_id}, 32'd0);
    chk("rst rsp_data", bus_a.rsp_data, 32'd0);
    chk("rst busy", {31'b0, bus_a.busy}, 32'd0);
    chk("rst ops_done", {16'b0, bus_a.ops_done}, 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);

    // ---- single op: requester 2, 2.0 * 3.0
    bus_a.req_dataA[95:64] = 32'h40000000;
    bus_a.req_dataB[95:64] = 32'h40400000;
    bus_a.req_valid = 4'b0100;
    #1;
    chk("single req_ready", {28'b0, bus_a.req_ready}, 32'h4);
    @(negedge clk);
    bus_a.req_valid = '0;
    chk("single exec busy", {31'b0, bus_a.busy}, 32'd1);
    chk("single exec rsp_valid", {31'b0, bus_a.rsp_valid}, 32'd0);
    chk("single mul_dataA", bus_a.mul_dataA, 32'h40000000);
    chk("single mul_dataB", bus_a.mul_dataB, 32'h40400000);
    @(negedge clk);
    chk("single rsp_valid", {31'b0, bus_a.rsp_valid}, 32'd1);
    chk("single rsp_id", {30'b0, bus_a.rsp_id}, 32'd2);
    chk("single rsp_data", bus_a.rsp_data, 32'h40C00000);
    @(negedge clk);
    chk("single ops_done", {16'b0, bus_a.ops_done}, 32'd1);
    chk("single idle rsp_valid", {31'b0, bus_a.rsp_valid}, 32'd0);
    chk("single idle busy", {31'b0, bus_a.busy}, 32'd0);

    // ---- round robin: all four valid, ptr back to 0 after reset
    rst_a = 1'b1;
    #1;
    rst_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_a.req_dataA[32*i +: 32] = 32'h3FC00000;
      bus_a.req_dataB[32*i +: 32] = 32'h3FC00000;
    end
    for (int i = 0; i < 5; i++) begin
      g_id[i]  = -1;
      g_cyc[i] = -100;
    end
    bus_a.req_valid = 4'b1111;
    #1;
    ng  = 0;
    cyc = 0;
    while (cyc < 40) begin
      if (bus_a.rsp_valid) chk("rr rsp_data", bus_a.rsp_data, 32'h40100000);
      if (|bus_a.req_ready) begin
        g_id[ng]  = oh2idx(bus_a.req_ready);
        g_cyc[ng] = cyc;
        ng++;
      end
      if (ng == 5) break;
      @(negedge clk);
      #1;
      cyc++;
    end
    @(negedge clk);
    bus_a.req_valid = '0;
    drain_a(32'h40100000);
    chk("rr grant count", ng, 5);
    for (int i = 0; i < 5; i++) chk("rr grant order", g_id[i], i % 4);
    for (int i = 1; i < 5; i++) chk("rr accept spacing", g_cyc[i] - g_cyc[i-1], 3);
    chk("rr ops_done", {16'b0, bus_a.ops_done}, 32'd5);

    // ---- backpressure: requester 1 (ptr=1), requester 3 waits meanwhile
    bus_a.rsp_ready = 1'b0;
    bus_a.req_dataA[63:32] = 32'h40000000;
    bus_a.req_dataB[63:32] = 32'h40400000;
    bus_a.req_valid = 4'b0010;
    #1;
    chk("bp req_ready", {28'b0, bus_a.req_ready}, 32'h2);
    @(negedge clk);
    bus_a.req_valid = 4'b1000;
    n = 0;
    while (!bus_a.rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("bp rsp_valid rise", {31'b0, bus_a.rsp_valid}, 32'd1);
    repeat (10) begin
      @(negedge clk);
      chk("bp rsp_valid", {31'b0, bus_a.rsp_valid}, 32'd1);
      chk("bp rsp_id", {30'b0, bus_a.rsp_id}, 32'd1);
      chk("bp rsp_data", bus_a.rsp_data, 32'h40C00000);
      chk("bp req_ready", {28'b0, bus_a.req_ready}, 32'd0);
      chk("bp busy", {31'b0, bus_a.busy}, 32'd1);
    end
    bus_a.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp release rsp_valid", {31'b0, bus_a.rsp_valid}, 32'd0);
    chk("bp release busy", {31'b0, bus_a.busy}, 32'd0);
    chk("bp release ops_done", {16'b0, bus_a.ops_done}, 32'd6);
    chk("bp waiting grant", {28'b0, bus_a.req_ready}, 32'h8);
    bus_a.req_valid = '0;
    @(negedge clk);

    // ---- saturation of ops_done
    force dut_a.ops_q = 16'hFFFE;
    @(negedge clk);
    release dut_a.ops_q;
    chk("sat preload", {16'b0, bus_a.ops_done}, 32'h0000FFFE);
    op_a(0, 32'h40000000, 32'h40400000, 32'h40C00000);
    chk("sat reach", {16'b0, bus_a.ops_done}, 32'h0000FFFF);
    op_a(1, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
    chk("sat hold", {16'b0, bus_a.ops_done}, 32'h0000FFFF);

    // ---- LAT=4: valid rises on the 5th negedge after the accept edge
    bus_b.req_dataA[31:0] = 32'h3FC00000;
    bus_b.req_dataB[31:0] = 32'h3FC00000;
    bus_b.req_valid = 4'b0001;
    #1;
    chk("lat4 req_ready", {28'b0, bus_b.req_ready}, 32'h1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) bus_b.req_valid = '0;
      if (k <= 4) begin
        chk("lat4 rsp_valid low", {31'b0, bus_b.rsp_valid}, 32'd0);
        chk("lat4 mul_dataA", bus_b.mul_dataA, 32'h3FC00000);
        chk("lat4 mul_dataB", bus_b.mul_dataB, 32'h3FC00000);
        chk("lat4 busy", {31'b0, bus_b.busy}, 32'd1);
      end else begin
        chk("lat4 rsp_valid", {31'b0, bus_b.rsp_valid}, 32'd1);
        chk("lat4 rsp_data", bus_b.rsp_data, 32'h40100000);
        chk("lat4 rsp_id", {30'b0, bus_b.rsp_id}, 32'd0);
      end
    end
    @(negedge clk);
    chk("lat4 ops_done", {16'b0, bus_b.ops_done}, 32'd1);
    chk("lat4 idle", {31'b0, bus_b.busy}, 32'd0);

    // ---- reset in the middle of EXEC
    bus_b.req_dataA[63:32] = 32'h40000000;
    bus_b.req_dataB[63:32] = 32'h40400000;
    bus_b.req_valid = 4'b0010;
    #1;
    chk("abort req_ready", {28'b0, bus_b.req_ready}, 32'h2);
    @(negedge clk);
    bus_b.req_valid = '0;
    @(negedge clk);
    a_hold = bus_b.mul_dataA;
    b_hold = bus_b.mul_dataB;
    chk("abort pre busy", {31'b0, bus_b.busy}, 32'd1);
    chk("abort pre mul_dataA", a_hold, 32'h40000000);
    chk("abort pre mul_dataB", b_hold, 32'h40400000);
    rst_b = 1'b1;
    #1;
    chk("abort rsp_valid", {31'b0, bus_b.rsp_valid}, 32'd0);
    chk("abort busy", {31'b0, bus_b.busy}, 32'd0);
    chk("abort mul_dataA", bus_b.mul_dataA, 32'd0);
    chk("abort mul_dataB", bus_b.mul_dataB, 32'd0);
    chk("abort ops_done", {16'b0, bus_b.ops_done}, 32'd0);
    chk("abort rsp_data", bus_b.rsp_data, 32'd0);
    @(negedge clk);
    rst_b = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus_b.rsp_valid) seen++;
    end
    chk("abort no response", seen, 0);
    chk("abort stays idle", {31'b0, bus_b.busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
